// File: rtl/mdio_pkg.sv
// Shared MDIO Clause-22 constants, monitor FSM encoding and status helpers.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_PHYSR  = 5'd17;

  // Frame count landmarks: last driven bit, turnaround ack sample, last data bit
  localparam logic [5:0] DRV_LAST = 6'd45;
  localparam logic [5:0] ACK_CNT  = 6'd47;
  localparam logic [5:0] LAST_CNT = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_RD_BMSR  = 3'd2,
    ST_RD_PHYSR = 3'd3,
    ST_UPDATE   = 3'd4
  } mon_state_t;

  typedef struct packed {
    logic       link_up;
    logic [1:0] speed;
    logic       full_duplex;
  } link_stat_t;

  // Value driven on MDIO at frame count k; counts past the address field read as 1
  function automatic logic frame_bit(input logic [4:0] phy, input logic [4:0] regad,
                                     input logic [5:0] k);
    logic [63:0] f;
    f = {32'hFFFF_FFFF, MDIO_ST, MDIO_OP_RD, phy, regad, 18'h3FFFF};
    return f[6'd63 - k];
  endfunction

  // A 1000M-reserved speed code (11) never counts as link up
  function automatic link_stat_t decode_status(input logic bmsr_ls, input logic [2:0] physr_mode,
                                               input logic physr_lnk);
    link_stat_t s;
    s.speed       = physr_mode[2:1];
    s.full_duplex = physr_mode[0];
    s.link_up     = bmsr_ls & physr_lnk & (physr_mode[2:1] != 2'b11);
    return s;
  endfunction

endpackage

// File: rtl/mdio_rd_frame.sv
// One 64-bit Clause-22 read frame: preamble/ST/OP/PHYAD/REGAD out, ack + 16 data bits in.
module mdio_rd_frame
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADR = 5'd1
) (
  input  logic        clk1m,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [4:0]  reg_adr,
  input  logic        mdio_i,
  output logic        done,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        mdio_o,
  output logic        mdio_out_en
);

  logic       busy;
  logic [5:0] cnt;
  logic [5:0] cnt_nx;
  logic [4:0] reg_q;

  assign cnt_nx = cnt + 6'd1;

  // Pad values are registered from the next count so bit k appears during count k
  always_ff @(posedge clk1m) begin
    if (rst || abort) begin
      busy        <= 1'b0;
      cnt         <= '0;
      reg_q       <= '0;
      done        <= 1'b0;
      ack         <= 1'b0;
      rdata       <= '0;
      mdio_o      <= 1'b1;
      mdio_out_en <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (cnt == ACK_CNT) ack <= ~mdio_i;
        if (cnt > ACK_CNT) rdata <= {rdata[14:0], mdio_i};
        if (cnt == LAST_CNT) begin
          busy        <= 1'b0;
          cnt         <= '0;
          done        <= 1'b1;
          mdio_o      <= 1'b1;
          mdio_out_en <= 1'b0;
        end else begin
          cnt         <= cnt_nx;
          mdio_o      <= frame_bit(PHY_ADR, reg_q, cnt_nx);
          mdio_out_en <= (cnt_nx <= DRV_LAST);
        end
      end else if (start) begin
        busy        <= 1'b1;
        cnt         <= '0;
        reg_q       <= reg_adr;
        ack         <= 1'b0;
        mdio_o      <= frame_bit(PHY_ADR, reg_adr, 6'd0);
        mdio_out_en <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/phy_link_mon.sv
// Periodic PHY link poller: reads BMSR then PHYSR and publishes link/speed/duplex.
module phy_link_mon
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADR  = 5'd1,
  parameter int         POLL_DIV = 50000
) (
  input  logic       clk1m,
  input  logic       rst,
  input  logic       init_done,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_out_en,
  output logic       mdc_o,
  output logic       link_up,
  output logic [1:0] speed,
  output logic       full_duplex,
  output logic       status_valid,
  output logic       link_change,
  output logic       poll_err
);

  localparam logic [15:0] TMR_LAST = 16'(POLL_DIV - 1);

  mon_state_t  state;
  logic [15:0] timer;
  logic        bmsr_ls;
  logic        start;
  logic [4:0]  reg_sel;
  logic        fr_done;
  logic        fr_ack;
  logic [15:0] fr_data;
  link_stat_t  nstat;
  logic        unused_bits;

  assign mdc_o       = clk1m;
  assign nstat       = decode_status(bmsr_ls, fr_data[15:13], fr_data[10]);
  assign unused_bits = ^{fr_data[12:11], fr_data[9:3], fr_data[1:0]};

  mdio_rd_frame #(.PHY_ADR(PHY_ADR)) u_frame (
    .clk1m       (clk1m),
    .rst         (rst),
    .abort       (~init_done),
    .start       (start),
    .reg_adr     (reg_sel),
    .mdio_i      (mdio_i),
    .done        (fr_done),
    .ack         (fr_ack),
    .rdata       (fr_data),
    .mdio_o      (mdio_o),
    .mdio_out_en (mdio_out_en)
  );

  // Frame launch: poll start from IDLE/WAIT, PHYSR read chained on an acked BMSR
  always_comb begin
    start   = 1'b0;
    reg_sel = REG_BMSR;
    if (init_done) begin
      case (state)
        ST_IDLE:    start = 1'b1;
        ST_WAIT:    start = (timer == TMR_LAST);
        ST_RD_BMSR: if (fr_done && fr_ack) begin
          start   = 1'b1;
          reg_sel = REG_PHYSR;
        end
        default:    start = 1'b0;
      endcase
    end
  end

  // Poll sequencer and registered status; init_done low overrides everything else
  always_ff @(posedge clk1m) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      bmsr_ls      <= 1'b0;
      link_up      <= 1'b0;
      speed        <= 2'b00;
      full_duplex  <= 1'b0;
      status_valid <= 1'b0;
      link_change  <= 1'b0;
      poll_err     <= 1'b0;
    end else begin
      link_change <= 1'b0;
      poll_err    <= 1'b0;
      if (!init_done) begin
        state        <= ST_IDLE;
        timer        <= '0;
        link_up      <= 1'b0;
        speed        <= 2'b00;
        full_duplex  <= 1'b0;
        status_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_RD_BMSR;
          ST_WAIT: begin
            if (timer == TMR_LAST) begin
              state <= ST_RD_BMSR;
              timer <= '0;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          ST_RD_BMSR: if (fr_done) begin
            if (fr_ack) begin
              bmsr_ls <= fr_data[2];
              state   <= ST_RD_PHYSR;
            end else begin
              poll_err <= 1'b1;
              state    <= ST_WAIT;
              timer    <= '0;
            end
          end
          ST_RD_PHYSR: if (fr_done) begin
            if (fr_ack) begin
              state <= ST_UPDATE;
            end else begin
              poll_err <= 1'b1;
              state    <= ST_WAIT;
              timer    <= '0;
            end
          end
          ST_UPDATE: begin
            link_up      <= nstat.link_up;
            speed        <= nstat.speed;
            full_duplex  <= nstat.full_duplex;
            status_valid <= 1'b1;
            link_change  <= nstat.link_up ^ link_up;
            state        <= ST_WAIT;
            timer        <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
